ahblite_master_bridge: RTL and testbench

AHBLITE_MASTER_BRIDGE -- requirements
Module: ahblite_master_bridge

---
 rtl/ahblite_master_bridge.sv | 182 ++++++++++++++++++
 tb/tb_ahblite_master_bridge.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahblite_master_bridge.sv
// Single-outstanding command/response to AHB-Lite master bridge.
// Misaligned or illegal-size commands are answered with an error and never reach the bus.
module ahblite_master_bridge #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  hsize_q, hsize_d;
  logic        hwrite_q, hwrite_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        err_q, err_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        accept;
  logic        cmd_illegal;
  logic [31:0] rd_shift;
  logic [31:0] rd_lane;
  logic [31:0] wr_lanes;

  assign accept      = cmd_valid && cmd_ready_q;
  assign cmd_illegal = (cmd_size == 2'd3) ||
                       ((cmd_size == 2'd1) && cmd_addr[0]) ||
                       ((cmd_size == 2'd2) && (cmd_addr[1:0] != 2'b00));

  // Bring the addressed lane down to bit 0, then zero-extend by size.
  assign rd_shift = HRDATA >> {haddr_q[1:0], 3'b000};

  always_comb begin
    case (hsize_q)
      2'd0:    rd_lane = {24'h0, rd_shift[7:0]};
      2'd1:    rd_lane = {16'h0, rd_shift[15:0]};
      2'd2:    rd_lane = HRDATA;
      default: rd_lane = 32'h0;
    endcase
  end

  always_comb begin
    case (hsize_q)
      2'd0:    wr_lanes = {4{wdata_q[7:0]}};
      2'd1:    wr_lanes = {2{wdata_q[15:0]}};
      default: wr_lanes = wdata_q;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= StIdle;
      haddr_q     <= 32'h0;
      hsize_q     <= 2'd0;
      hwrite_q    <= 1'b0;
      htrans_q    <= TransIdle;
      wdata_q     <= 32'h0;
      hwdata_q    <= 32'h0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      htrans_q    <= htrans_d;
      wdata_q     <= wdata_d;
      hwdata_q    <= hwdata_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = cmd_illegal ? StResp : StAddr;
      StAddr:  if (HREADY) state_d = StData;
      StData:  if (HREADY) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    haddr_d     = haddr_q;
    hsize_d     = hsize_q;
    hwrite_d    = hwrite_q;
    htrans_d    = TransIdle;
    wdata_d     = wdata_q;
    hwdata_d    = hwdata_q;
    err_d       = err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cmd_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          err_d = 1'b0;
          if (cmd_illegal) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            haddr_d  = cmd_addr;
            hsize_d  = cmd_size;
            hwrite_d = cmd_write;
            wdata_d  = cmd_wdata;
            htrans_d = TransNonseq;
          end
        end
      end
      StAddr: begin
        if (HREADY) begin
          hwdata_d = wr_lanes;
        end else begin
          htrans_d = TransNonseq;
        end
      end
      StData: begin
        if (HRESP) err_d = 1'b1;
        if (HREADY) begin
          rsp_err_d   = err_q || HRESP;
          rsp_rdata_d = (err_q || HRESP || hwrite_q) ? 32'h0 : rd_lane;
        end
      end
      StResp: ;
      default: ;
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HSIZE     = {1'b0, hsize_q};
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahblite_master_bridge.sv
// Directed bench for ahblite_master_bridge: a driven AHB slave and hand-computed expectations.
module tb_ahblite_master_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int tests  = 0;
  int failed = 0;

  ahblite_master_bridge #(.HPROT_VAL(4'b0011)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HMASTLOCK (HMASTLOCK),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  always #5 HCLK = ~HCLK;

  // Step one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one command for exactly one edge; cmd_ready is expected high.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    HRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_size  = 2'd0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    HRDATA    = 32'h0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;

    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_htrans", HTRANS, 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("hburst", HBURST, 0);
    chk("hprot", HPROT, 4'b0011);
    chk("hmastlock", HMASTLOCK, 0);
    HRESET = 1'b0;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Zero-wait word read.
    HRDATA = 32'hDEAD_BEEF;
    issue(1'b0, 32'h2000_0004, 2'd2, 32'h0);
    chk("t1_htrans_nonseq", HTRANS, 2'b10);
    chk("t1_haddr", HADDR, 32'h2000_0004);
    chk("t1_hsize", HSIZE, 3'd2);
    chk("t1_hwrite", HWRITE, 0);
    chk("t1_cmd_ready_busy", cmd_ready, 0);
    tick();
    chk("t1_htrans_idle_data", HTRANS, 2'b00);
    chk("t1_no_rsp_yet", rsp_valid, 0);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("t1_err", rsp_err, 0);
    consume();
    chk("t1_rsp_done", rsp_valid, 0);
    chk("t1_idle_ready", cmd_ready, 1);

    // Byte write with two wait states.
    issue(1'b1, 32'h0000_0013, 2'd0, 32'h0000_005A);
    chk("t2_hwrite", HWRITE, 1);
    chk("t2_hsize", HSIZE, 3'd0);
    tick();
    HREADY = 1'b0;
    chk("t2_hwdata_c1", HWDATA, 32'h5A5A_5A5A);
    tick();
    chk("t2_hwdata_c2", HWDATA, 32'h5A5A_5A5A);
    chk("t2_wait_no_rsp", rsp_valid, 0);
    tick();
    HREADY = 1'b1;
    chk("t2_hwdata_c3", HWDATA, 32'h5A5A_5A5A);
    chk("t2_wait2_no_rsp", rsp_valid, 0);
    tick();
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_err", rsp_err, 0);
    chk("t2_rdata_write", rsp_rdata, 0);
    consume();

    // Halfword read, upper lane, then held response under backpressure.
    HRDATA = 32'h1234_ABCD;
    issue(1'b0, 32'h0000_0002, 2'd1, 32'h0);
    chk("t3_hsize", HSIZE, 3'd1);
    tick();
    tick();
    HRDATA = 32'hFFFF_FFFF;
    chk("t3_rdata", rsp_rdata, 32'h0000_1234);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_rdata", rsp_rdata, 32'h0000_1234);
      chk("t3_hold_err", rsp_err, 0);
      chk("t3_hold_cmd_ready", cmd_ready, 0);
    end
    consume();

    // Byte read of lane 3.
    HRDATA = 32'hA1B2_C3D4;
    issue(1'b0, 32'h0000_0003, 2'd0, 32'h0);
    tick();
    tick();
    chk("t3b_rdata_byte3", rsp_rdata, 32'h0000_00A1);
    consume();

    // Two-cycle error response on a word write.
    issue(1'b1, 32'h0000_0100, 2'd2, 32'hCAFE_F00D);
    tick();
    HRESP  = 1'b1;
    HREADY = 1'b0;
    chk("t4_hwdata_word", HWDATA, 32'hCAFE_F00D);
    tick();
    HREADY = 1'b1;
    tick();
    HRESP = 1'b0;
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_err", rsp_err, 1);
    chk("t4_rdata", rsp_rdata, 0);
    consume();

    // Misaligned word read: rejected without a bus transfer.
    issue(1'b0, 32'h0000_0006, 2'd2, 32'h0);
    chk("t5_no_nonseq", HTRANS, 2'b00);
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_err", rsp_err, 1);
    chk("t5_rdata", rsp_rdata, 0);
    consume();

    // Illegal size.
    issue(1'b0, 32'h0000_0000, 2'd3, 32'h0);
    chk("t5b_no_nonseq", HTRANS, 2'b00);
    chk("t5b_err", rsp_err, 1);
    consume();

    // Reset pulsed during a stalled data phase.
    issue(1'b0, 32'h0000_0040, 2'd2, 32'h0);
    tick();
    HREADY = 1'b0;
    tick();
    HRESET = 1'b1;
    tick();
    chk("t6_htrans", HTRANS, 2'b00);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_cmd_ready_rst", cmd_ready, 0);
    HRESET = 1'b0;
    HREADY = 1'b1;
    tick();
    chk("t6_cmd_ready_after", cmd_ready, 1);
    HRDATA = 32'h0BAD_F00D;
    issue(1'b0, 32'h0000_0044, 2'd2, 32'h0);
    chk("t6_new_nonseq", HTRANS, 2'b10);
    tick();
    tick();
    chk("t6_new_valid", rsp_valid, 1);
    chk("t6_new_rdata", rsp_rdata, 32'h0BAD_F00D);
    chk("t6_new_err", rsp_err, 0);
    consume();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
